// File: rtl/uart_pkg.sv
// uart_pkg: baud generator defaults, config record type and reset helper.
// BAUD_FRAC_EN adds the fractional divisor field to baud_cfg_t.
package uart_pkg;
    localparam int unsigned BAUD_DIV_W       = 16;
    localparam int unsigned BAUD_FRAC_W      = 4;
    localparam int unsigned BAUD_OS_RATIO    = 16;
    localparam int unsigned BAUD_DEFAULT_DIV = 54;

    typedef struct packed {
        logic [BAUD_DIV_W-1:0]  div;
`ifdef BAUD_FRAC_EN
        logic [BAUD_FRAC_W-1:0] frac;
`endif
    } baud_cfg_t;

    function automatic baud_cfg_t cfg_reset(input int unsigned d);
        baud_cfg_t c;
        c     = '0;
        c.div = BAUD_DIV_W'(d);
        return c;
    endfunction
endpackage

// File: rtl/baud_div_counter.sv
// baud_div_counter: period counter and registered os_tick; wrap is the combinational period end.
// BAUD_FRAC_EN adds the fractional accumulator that stretches carried periods by one cycle.
module baud_div_counter
    import uart_pkg::*;
#(
    parameter int unsigned DIV_W  = BAUD_DIV_W
`ifdef BAUD_FRAC_EN
    , parameter int unsigned FRAC_W = BAUD_FRAC_W
`endif
) (
    input  logic              sys_clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              restart,
    input  logic [DIV_W-1:0]  div,
`ifdef BAUD_FRAC_EN
    input  logic [FRAC_W-1:0] frac,
`endif
    output logic              wrap,
    output logic              os_tick
);
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic              os_tick_q, os_tick_d;
    logic              clr, term;
`ifdef BAUD_FRAC_EN
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              ext_q, ext_d;
    logic [FRAC_W:0]   sum;
`endif

    always_comb begin
        clr = !enable || restart;
`ifdef BAUD_FRAC_EN
        // A carried fraction makes this period div+1 long, so the terminal count is div itself.
        term = ext_q ? (cnt_q == div) : (cnt_q == div - DIV_W'(1));
`else
        term = cnt_q == div - DIV_W'(1);
`endif
        wrap      = !clr && term;
        cnt_d     = (clr || wrap) ? '0 : cnt_q + DIV_W'(1);
        os_tick_d = wrap;
`ifdef BAUD_FRAC_EN
        sum   = {1'b0, acc_q} + {1'b0, frac};
        acc_d = clr ? '0 : wrap ? sum[FRAC_W-1:0] : acc_q;
        ext_d = clr ? 1'b0 : wrap ? sum[FRAC_W] : ext_q;
`endif
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            os_tick_q <= 1'b0;
`ifdef BAUD_FRAC_EN
            acc_q     <= '0;
            ext_q     <= 1'b0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            os_tick_q <= os_tick_d;
`ifdef BAUD_FRAC_EN
            acc_q     <= acc_d;
            ext_q     <= ext_d;
`endif
        end
    end

    assign os_tick = os_tick_q;
endmodule

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: programmable baud clock-enable generator with shadowed config and bit/mid ticks.
// BAUD_FRAC_EN enables the cfg_frac port and fractional period correction.
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int unsigned DIV_W       = BAUD_DIV_W,
    parameter int unsigned OS_RATIO    = BAUD_OS_RATIO,
    parameter int unsigned DEFAULT_DIV = BAUD_DEFAULT_DIV
`ifdef BAUD_FRAC_EN
    , parameter int unsigned FRAC_W    = BAUD_FRAC_W
`endif
) (
    input  logic                        sys_clk,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic                        restart,
    input  logic                        cfg_wr,
    input  logic [DIV_W-1:0]            cfg_div,
`ifdef BAUD_FRAC_EN
    input  logic [FRAC_W-1:0]           cfg_frac,
`endif
    output logic                        cfg_pending,
    output logic                        cfg_err,
    output logic                        os_tick,
    output logic                        mid_tick,
    output logic                        bit_tick,
    output logic [$clog2(OS_RATIO)-1:0] os_phase
);
    localparam int unsigned PH_W = $clog2(OS_RATIO);

    baud_cfg_t       cfg_act_q, cfg_act_d, cfg_shd_q, cfg_shd_d, cfg_in;
    logic            cfg_pending_q, cfg_pending_d, cfg_err_q, cfg_err_d;
    logic            mid_tick_q, mid_tick_d, bit_tick_q, bit_tick_d;
    logic [PH_W-1:0] os_phase_q, os_phase_d;
    logic            wr_ok, apply, wrap;

    baud_div_counter #(
        .DIV_W  (DIV_W)
`ifdef BAUD_FRAC_EN
        , .FRAC_W (FRAC_W)
`endif
    ) u_cnt (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .enable  (enable),
        .restart (restart),
        .div     (cfg_act_q.div),
`ifdef BAUD_FRAC_EN
        .frac    (cfg_act_q.frac),
`endif
        .wrap    (wrap),
        .os_tick (os_tick)
    );

    always_comb begin
        cfg_in     = '0;
        cfg_in.div = cfg_div;
`ifdef BAUD_FRAC_EN
        cfg_in.frac = cfg_frac;
`endif
        wr_ok     = cfg_wr && (cfg_div != '0);
        apply     = restart || !enable || wrap;
        cfg_shd_d = wr_ok ? cfg_in : cfg_shd_q;
        // A write landing on an apply cycle goes straight to active instead of waiting a period.
        cfg_act_d = !apply ? cfg_act_q : wr_ok ? cfg_in : cfg_pending_q ? cfg_shd_q : cfg_act_q;
        cfg_pending_d = !apply && (wr_ok || cfg_pending_q);
        cfg_err_d     = cfg_wr && (cfg_div == '0);
        os_phase_d    = (restart || !enable) ? '0 : wrap ? os_phase_q + PH_W'(1) : os_phase_q;
        bit_tick_d    = wrap && (os_phase_q == PH_W'(OS_RATIO - 1));
        mid_tick_d    = wrap && (os_phase_q == PH_W'(OS_RATIO / 2 - 1));
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_act_q     <= cfg_reset(DEFAULT_DIV);
            cfg_shd_q     <= '0;
            cfg_pending_q <= 1'b0;
            cfg_err_q     <= 1'b0;
            os_phase_q    <= '0;
            bit_tick_q    <= 1'b0;
            mid_tick_q    <= 1'b0;
        end else begin
            cfg_act_q     <= cfg_act_d;
            cfg_shd_q     <= cfg_shd_d;
            cfg_pending_q <= cfg_pending_d;
            cfg_err_q     <= cfg_err_d;
            os_phase_q    <= os_phase_d;
            bit_tick_q    <= bit_tick_d;
            mid_tick_q    <= mid_tick_d;
        end
    end

    assign cfg_pending = cfg_pending_q;
    assign cfg_err     = cfg_err_q;
    assign os_phase    = os_phase_q;
    assign bit_tick    = bit_tick_q;
    assign mid_tick    = mid_tick_q;
endmodule

// File: tb/tb_baud_tick_gen.sv
// tb_baud_tick_gen: directed scoreboard bench for baud_tick_gen with expected periods queued per step.
// Define BAUD_FRAC_EN to add the fractional-divisor scenario.
module tb_baud_tick_gen;
    logic        sys_clk = 1'b0, reset_n = 1'b0, enable = 1'b0, restart = 1'b0, cfg_wr = 1'b0;
    logic [15:0] cfg_div = '0;
`ifdef BAUD_FRAC_EN
    logic [3:0]  cfg_frac = '0;
`endif
    logic        cfg_pending, cfg_err, os_tick, mid_tick, bit_tick;
    logic [3:0]  os_phase;
    int          checks = 0, failures = 0;
    int          exp_q[$];
    int          n, sum, longs;

    always #5 sys_clk = ~sys_clk;

    baud_tick_gen dut (
        .sys_clk     (sys_clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .restart     (restart),
        .cfg_wr      (cfg_wr),
        .cfg_div     (cfg_div),
`ifdef BAUD_FRAC_EN
        .cfg_frac    (cfg_frac),
`endif
        .cfg_pending (cfg_pending),
        .cfg_err     (cfg_err),
        .os_tick     (os_tick),
        .mid_tick    (mid_tick),
        .bit_tick    (bit_tick),
        .os_phase    (os_phase)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int k = 1);
        repeat (k) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic wait_os(output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!os_tick && cnt < 2000);
        chk("os_tick_seen", os_tick, 1'b1);
    endtask

    task automatic period(input string tag);
        wait_os(n);
        chk(tag, n, exp_q.pop_front());
    endtask

    initial begin
        step(2);
        chk("rst_os_tick", os_tick, 0);
        chk("rst_mid_tick", mid_tick, 0);
        chk("rst_bit_tick", bit_tick, 0);
        chk("rst_phase", os_phase, 0);
        chk("rst_pending", cfg_pending, 0);
        chk("rst_err", cfg_err, 0);
        reset_n = 1'b1;
        enable  = 1'b1;
        repeat (16) exp_q.push_back(54);
        for (int i = 0; i < 16; i++) begin
            period("default_period");
            chk("default_phase", os_phase, (i + 1) % 16);
            chk("default_bit_tick", bit_tick, i == 15);
            chk("default_mid_tick", mid_tick, i == 7);
        end
        step(20);
        cfg_wr = 1'b1; cfg_div = 16'd10; step(); cfg_wr = 1'b0;
        chk("pend_after_wr", cfg_pending, 1);
        step(5);
        chk("pend_hold", cfg_pending, 1);
        cfg_wr = 1'b1; cfg_div = 16'd20; step(); cfg_wr = 1'b0;
        exp_q.push_back(27);
        period("period_before_apply");
        chk("pend_clear_at_tick", cfg_pending, 0);
        repeat (3) exp_q.push_back(20);
        repeat (3) period("period_last_write_wins");
        cfg_wr = 1'b1; cfg_div = 16'd0; step(); cfg_wr = 1'b0;
        chk("err_pulse", cfg_err, 1);
        chk("err_no_pending", cfg_pending, 0);
        step();
        chk("err_one_cycle", cfg_err, 0);
        exp_q.push_back(18);
        exp_q.push_back(20);
        period("period_after_err");
        period("period_div_kept");
        cfg_wr = 1'b1; cfg_div = 16'd54; step(); cfg_wr = 1'b0;
        exp_q.push_back(19);
        period("period_to_54");
        chk("phase_before_restart", os_phase, 7);
        step(29);
        restart = 1'b1; step(); restart = 1'b0;
        chk("restart_no_tick", os_tick, 0);
        chk("restart_phase", os_phase, 0);
        repeat (8) exp_q.push_back(54);
        for (int i = 0; i < 8; i++) begin
            period("period_after_restart");
            chk("mid_after_restart", mid_tick, i == 7);
        end
        step(53);
        restart = 1'b1; step(); restart = 1'b0;
        chk("restart_beats_tick", os_tick, 0);
        chk("restart_prio_phase", os_phase, 0);
        exp_q.push_back(54);
        period("restart_prio_period");
        step(3);
        restart = 1'b1; cfg_wr = 1'b1; cfg_div = 16'd5; step(); restart = 1'b0; cfg_wr = 1'b0;
        chk("restart_wr_pending", cfg_pending, 0);
        exp_q.push_back(5);
        exp_q.push_back(5);
        repeat (2) period("restart_wr_period");
        enable = 1'b0; cfg_wr = 1'b1; cfg_div = 16'd1; step(); cfg_wr = 1'b0;
        chk("en_low_pending", cfg_pending, 0);
        chk("en_low_tick", os_tick, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("en_low_tick", os_tick, 0);
            chk("en_low_phase", os_phase, 0);
        end
        enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            chk("div1_tick", os_tick, 1);
            chk("div1_bit_tick", bit_tick, i == 15);
        end
        cfg_wr = 1'b1; cfg_div = 16'd9; step(); cfg_wr = 1'b0;
        exp_q.push_back(9);
        period("period_div9");
        cfg_wr = 1'b1; cfg_div = 16'd4; step(); cfg_wr = 1'b0;
        chk("pend_before_rst", cfg_pending, 1);
        chk("phase_before_rst", os_phase, 2);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_pending", cfg_pending, 0);
        chk("async_rst_phase", os_phase, 0);
        step();
        reset_n = 1'b1;
        exp_q.push_back(54);
        period("period_after_reset");
`ifdef BAUD_FRAC_EN
        enable = 1'b0; cfg_wr = 1'b1; cfg_div = 16'd54; cfg_frac = 4'd4; step();
        cfg_wr = 1'b0; enable = 1'b1;
        exp_q.push_back(54);
        period("frac_first");
        sum   = 0;
        longs = 0;
        for (int k = 2; k <= 17; k++) exp_q.push_back((k % 4 == 1) ? 55 : 54);
        for (int i = 0; i < 16; i++) begin
            wait_os(n);
            chk("frac_period", n, exp_q.pop_front());
            sum   += n;
            longs += (n == 55) ? 1 : 0;
        end
        chk("frac_total", sum, 868);
        chk("frac_long_periods", longs, 4);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
